riio_supply_seq: RTL and testbench

Parametrised N-channel IO supply power sequencer for the GF22FDX EG1V8 pad ring. It drives the enable inputs of NUM_CH switched IO/core supply segments in a fixed order and monitors each segment's power-good indication. It powers segments up in ascending order and down in descending order, with a programmable settle delay between steps and a programmable power-good timeout. It sits in the always-on core domain next to the supply pad cells and gates pad-ring readiness for the rest of the chip.

---
 rtl/riio_supply_seq.sv | 188 ++++++++++++++++++
 tb/tb_riio_supply_seq.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riio_supply_seq.sv
// Purpose: N-channel IO supply sequencer. Segments power up in ascending order
//          and down in descending order, with a settle delay between steps.
//          Each power-up step waits for power-good, bounded by a timeout.
// Latency: en_i to sw_en_o[0] is one cycle. Each up-step takes 1 + (dly_i+1)
//          cycles plus synchroniser latency. Each down-step takes dly_i+1 cycles.
// Backpressure: none. en_i is a level request and is sampled every cycle.
//          A segment that fails power-good latches the sticky fault state.
//          Only clr_i with en_i low leaves that state.
// Ports:   clk_i/rst_ni always-on clock and async active-low reset.
//          en_i     up/down request; clr_i fault clear.
//          dly_i    settle delay; tmo_i power-good timeout. Both quasi-static.
//          pgood_i  per-segment power-good.
//          sw_en_o  switch enables; ready_o all segments up.
//          busy_o   sequencing; fault_o/fault_ch_o sticky fault and its segment.
// Config:  define RIIO_PGOOD_SYNC_EN to pass pgood_i through a 2-flop
//          synchroniser (+2 cycles). Leave it undefined when pgood_i is
//          already synchronous to clk_i.
module riio_supply_seq #(
    parameter int NUM_CH = 4,
    parameter int DLY_W  = 8,
    parameter int TMO_W  = 12,
    localparam int IDX_W = $clog2(NUM_CH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic [DLY_W-1:0]  dly_i,
    input  logic [TMO_W-1:0]  tmo_i,
    input  logic [NUM_CH-1:0] pgood_i,
    output logic [NUM_CH-1:0] sw_en_o,
    output logic              ready_o,
    output logic              busy_o,
    output logic              fault_o,
    output logic [IDX_W-1:0]  fault_ch_o
);
    localparam int TIM_W = (DLY_W > TMO_W) ? DLY_W : TMO_W;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CH - 1);

    typedef enum logic [2:0] {
        OFF, UP_WAIT_PG, UP_SETTLE, ON, DOWN_SETTLE, FAULT
    } state_t;

    state_t            state, nxt_state;
    logic [IDX_W-1:0]  idx, nxt_idx, idx_inc, idx_dec, drop_ch, nxt_ch;
    logic [TIM_W-1:0]  timer, nxt_timer, timer_inc;
    logic [NUM_CH-1:0] pg_s, nxt_sw, idx_bit;
    logic              dly_hit, tmo_hit;

`ifdef RIIO_PGOOD_SYNC_EN
    logic [NUM_CH-1:0] pg_meta;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pg_meta <= '0;
            pg_s    <= '0;
        end else begin
            pg_meta <= pgood_i;
            pg_s    <= pg_meta;
        end
    end
`else
    assign pg_s = pgood_i;
`endif

    // The timer saturates so that a long dwell can never wrap into a false match.
    assign timer_inc = (&timer) ? timer : timer + 1'b1;
    assign dly_hit   = (timer == TIM_W'(dly_i));
    assign tmo_hit   = (timer == TIM_W'(tmo_i));
    assign idx_inc   = idx + 1'b1;
    assign idx_dec   = idx - 1'b1;
    assign idx_bit   = NUM_CH'(1) << idx;

    // The scan runs from the top down, so the lowest segment that lost power-good wins.
    always_comb begin
        drop_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (!pg_s[i]) drop_ch = IDX_W'(i);
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        nxt_timer = timer_inc;
        nxt_sw    = sw_en_o;
        nxt_ch    = fault_ch_o;
        case (state)
            OFF: begin
                nxt_timer = '0;
                nxt_sw    = '0;
                if (en_i) begin
                    nxt_idx   = '0;
                    nxt_sw    = NUM_CH'(1);
                    nxt_state = UP_WAIT_PG;
                end
            end
            UP_WAIT_PG: begin
                if (!en_i) begin
                    // An abort unwinds from the segment currently being raised.
                    nxt_sw    = sw_en_o & ~idx_bit;
                    nxt_timer = '0;
                    nxt_state = DOWN_SETTLE;
                end else if (pg_s[idx]) begin
                    nxt_timer = '0;
                    nxt_state = UP_SETTLE;
                end else if (tmo_hit) begin
                    nxt_sw    = '0;
                    nxt_ch    = idx;
                    nxt_state = FAULT;
                end
            end
            UP_SETTLE: begin
                if (!en_i) begin
                    nxt_sw    = sw_en_o & ~idx_bit;
                    nxt_timer = '0;
                    nxt_state = DOWN_SETTLE;
                end else if (dly_hit) begin
                    nxt_timer = '0;
                    if (idx == LAST) begin
                        nxt_state = ON;
                    end else begin
                        nxt_idx         = idx_inc;
                        nxt_sw[idx_inc] = 1'b1;
                        nxt_state       = UP_WAIT_PG;
                    end
                end
            end
            ON: begin
                nxt_timer = '0;
                if (!en_i) begin
                    nxt_sw[LAST] = 1'b0;
                    nxt_idx      = LAST;
                    nxt_state    = DOWN_SETTLE;
                end else if (!(&pg_s)) begin
                    nxt_sw    = '0;
                    nxt_ch    = drop_ch;
                    nxt_state = FAULT;
                end
            end
            DOWN_SETTLE: begin
                // A new request is held off until the ring is fully down.
                if (dly_hit) begin
                    nxt_timer = '0;
                    if (idx == '0) begin
                        nxt_state = OFF;
                    end else begin
                        nxt_idx         = idx_dec;
                        nxt_sw[idx_dec] = 1'b0;
                    end
                end
            end
            FAULT: begin
                nxt_timer = '0;
                nxt_sw    = '0;
                if (clr_i && !en_i) nxt_state = OFF;
            end
            default: begin
                nxt_timer = '0;
                nxt_sw    = '0;
                nxt_state = OFF;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= OFF;
            idx        <= '0;
            timer      <= '0;
            sw_en_o    <= '0;
            ready_o    <= 1'b0;
            busy_o     <= 1'b0;
            fault_o    <= 1'b0;
            fault_ch_o <= '0;
        end else begin
            state      <= nxt_state;
            idx        <= nxt_idx;
            timer      <= nxt_timer;
            sw_en_o    <= nxt_sw;
            ready_o    <= (nxt_state == ON);
            busy_o     <= (nxt_state == UP_WAIT_PG) || (nxt_state == UP_SETTLE) ||
                          (nxt_state == DOWN_SETTLE);
            fault_o    <= (nxt_state == FAULT);
            fault_ch_o <= nxt_ch;
        end
    end
endmodule

// File: tb/tb_riio_supply_seq.sv
// Purpose: self-checking bench for riio_supply_seq (NUM_CH=4). It runs a
//          per-cycle vector table, hand sequences for the corner cases, and
//          randomised power-good delays checked against an arithmetic timeline.
// Latency: inputs are driven 1 time unit after each rising edge. Outputs are
//          sampled at the same point.
// Backpressure: not applicable.
module tb_riio_supply_seq;
    localparam int NUM_CH = 4;
    localparam int IDX_W  = 2;
`ifdef RIIO_PGOOD_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en, clr;
    logic [7:0]        dly;
    logic [11:0]       tmo;
    logic [NUM_CH-1:0] pgood;
    logic [NUM_CH-1:0] sw_en_o;
    logic              ready_o, busy_o, fault_o;
    logic [IDX_W-1:0]  fault_ch_o;

    riio_supply_seq #(.NUM_CH(NUM_CH), .DLY_W(8), .TMO_W(12)) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr), .dly_i(dly),
        .tmo_i(tmo), .pgood_i(pgood), .sw_en_o(sw_en_o), .ready_o(ready_o),
        .busy_o(busy_o), .fault_o(fault_o), .fault_ch_o(fault_ch_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    bit loop_en = 1'b0;
    logic [NUM_CH-1:0] kill = '0;
    int pdly[NUM_CH];
    int age[NUM_CH];

    typedef struct {
        logic       en;
        logic       clr;
        logic [3:0] pg;
        logic [3:0] sw;
        logic       rdy;
        logic       busy;
        logic       flt;
        logic [1:0] ch;
    } vec_t;
    vec_t tv[22];

    function automatic logic [31:0] pack(logic [3:0] sw, logic r, logic b, logic f,
                                         logic [1:0] ch);
        return {23'd0, sw, r, b, f, ch};
    endfunction

    // The fault index is only meaningful while a fault is expected.
    function automatic logic [31:0] obs_m(logic expf);
        logic [31:0] o;
        o = {23'd0, sw_en_o, ready_o, busy_o, fault_o, fault_ch_o};
        if (!expf) o[1:0] = 2'd0;
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Loopback supply model: segment k reports good pdly[k] cycles after its enable rises.
    task automatic drive_pg();
        logic [NUM_CH-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_CH; k++)
            v[k] = sw_en_o[k] && (age[k] >= pdly[k]) && !kill[k];
        pgood = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (loop_en) begin
            for (int k = 0; k < NUM_CH; k++)
                age[k] = sw_en_o[k] ? age[k] + 1 : -1;
            drive_pg();
        end
    endtask

    // Up-sequence timeline from arithmetic. Segment k is enabled at T[k]. Its
    // power-good is seen p+L cycles later. A pass costs one detect cycle plus
    // dly+1 settle cycles. A miss faults tmo+1 cycles after T[k].
    task automatic run_up(input int dly_v, input int tmo_v, output bit faulted);
        int T[NUM_CH];
        int t, f_t, r_t, fch, nreach, bad, base, end_t;
        logic [3:0]  sw;
        logic [31:0] exp;
        en = 1'b0; clr = 1'b0; dly = 8'(dly_v); tmo = 12'(tmo_v);
        repeat (3) step();
        t = 1; faulted = 1'b0; f_t = 0; r_t = 0; fch = 0; nreach = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            T[k] = t;
            nreach = k + 1;
            if (pdly[k] + L <= tmo_v) begin
                t = t + pdly[k] + L + dly_v + 2;
            end else begin
                f_t = t + tmo_v + 1; fch = k; faulted = 1'b1;
                break;
            end
        end
        if (!faulted) r_t = t;
        end_t = faulted ? f_t + 2 : r_t + 2;
        bad = 0;
        base = cyc;
        en = 1'b1;
        for (int s = 1; s <= end_t; s++) begin
            step();
            t = cyc - base;
            if (faulted && t >= f_t) begin
                exp = pack(4'b0, 1'b0, 1'b0, 1'b1, 2'(fch));
            end else begin
                sw = '0;
                for (int k = 0; k < nreach; k++) sw[k] = (t >= T[k]);
                if (!faulted && t >= r_t) exp = pack(sw, 1'b1, 1'b0, 1'b0, 2'd0);
                else                      exp = pack(sw, 1'b0, 1'b1, 1'b0, 2'd0);
            end
            if (obs_m(exp[2]) !== exp) bad++;
        end
        check($sformatf("up_trace dly=%0d tmo=%0d p=%0d/%0d/%0d/%0d", dly_v, tmo_v,
                        pdly[0], pdly[1], pdly[2], pdly[3]), 32'(bad), 32'd0);
    endtask

    // Down-sequence: segment k is cleared (NUM_CH-1-k)*(dly+1) cycles after the
    // first clear. OFF follows one more dwell after segment 0.
    task automatic run_down(input int dly_v);
        int base, t, bad, clr_t;
        logic [3:0] sw;
        logic       bz;
        bad = 0;
        base = cyc;
        en = 1'b0;
        for (int s = 1; s <= NUM_CH * (dly_v + 1) + 2; s++) begin
            step();
            t = cyc - base;
            for (int k = 0; k < NUM_CH; k++) begin
                clr_t = 1 + (NUM_CH - 1 - k) * (dly_v + 1);
                sw[k] = (t < clr_t);
            end
            bz = (t < 1 + NUM_CH * (dly_v + 1));
            if (obs_m(1'b0) !== pack(sw, 1'b0, bz, 1'b0, 2'd0)) bad++;
        end
        check($sformatf("down_trace dly=%0d", dly_v), 32'(bad), 32'd0);
    endtask

    task automatic fault_clear();
        en = 1'b1; clr = 1'b1;
        step();
        check("clr_ignored_with_en", {31'd0, fault_o}, 32'd1);
        en = 1'b0; clr = 1'b1;
        step();
        check("clr_exit", obs_m(1'b0), pack(4'b0, 1'b0, 1'b0, 1'b0, 2'd0));
        clr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit f;
        int base, t1;
        rst_n = 1'b1; en = 1'b0; clr = 1'b0; dly = 8'd3; tmo = 12'd10; pgood = '0;
        for (int k = 0; k < NUM_CH; k++) begin pdly[k] = 0; age[k] = -1; end
        #1 rst_n = 1'b0;
        #1 check("reset_state", obs_m(1'b1), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();

`ifndef RIIO_PGOOD_SYNC_EN
        // Vector table: dly=0, tmo=1, power-good driven directly.
        tv[0]  = '{1'b1, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0, 2'd0};
        tv[1]  = '{1'b1, 1'b0, 4'b0001, 4'b0001, 1'b0, 1'b1, 1'b0, 2'd0};
        tv[2]  = '{1'b1, 1'b0, 4'b0001, 4'b0011, 1'b0, 1'b1, 1'b0, 2'd0};
        tv[3]  = '{1'b1, 1'b0, 4'b0001, 4'b0011, 1'b0, 1'b1, 1'b0, 2'd0};
        tv[4]  = '{1'b1, 1'b0, 4'b0011, 4'b0011, 1'b0, 1'b1, 1'b0, 2'd0};
        tv[5]  = '{1'b1, 1'b0, 4'b0011, 4'b0111, 1'b0, 1'b1, 1'b0, 2'd0};
        tv[6]  = '{1'b1, 1'b0, 4'b0111, 4'b0111, 1'b0, 1'b1, 1'b0, 2'd0};
        tv[7]  = '{1'b1, 1'b0, 4'b0111, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0};
        tv[8]  = '{1'b1, 1'b0, 4'b1111, 4'b1111, 1'b0, 1'b1, 1'b0, 2'd0};
        tv[9]  = '{1'b1, 1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0};
        tv[10] = '{1'b1, 1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd0};
        tv[11] = '{1'b0, 1'b0, 4'b1111, 4'b0111, 1'b0, 1'b1, 1'b0, 2'd0};
        tv[12] = '{1'b1, 1'b0, 4'b0000, 4'b0011, 1'b0, 1'b1, 1'b0, 2'd0};
        tv[13] = '{1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0, 2'd0};
        tv[14] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd0};
        tv[15] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0};
        tv[16] = '{1'b1, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0, 2'd0};
        tv[17] = '{1'b1, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0, 2'd0};
        tv[18] = '{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0};
        tv[19] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0};
        tv[20] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0};
        tv[21] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0};
        dly = 8'd0; tmo = 12'd1; loop_en = 1'b0;
        for (int i = 0; i < 22; i++) begin
            en = tv[i].en; clr = tv[i].clr; pgood = tv[i].pg;
            step();
            check($sformatf("vec%0d", i), obs_m(tv[i].flt),
                  pack(tv[i].sw, tv[i].rdy, tv[i].busy, tv[i].flt, tv[i].ch));
        end
        clr = 1'b0; en = 1'b0; pgood = '0;
`endif

        loop_en = 1'b1;
        step();

        // Full up then down sequence with immediate power-good.
        run_up(3, 10, f);
        run_down(3);

        // Segment 2 never reports good: timeout fault on channel 2, then clear.
        pdly[2] = 100000;
        run_up(3, 10, f);
        fault_clear();
        pdly[2] = 0;

        // Power-good glitch on segment 1 while ON; the fault stays latched.
        run_up(3, 10, f);
        kill[1] = 1'b1;
        drive_pg();
        repeat (L + 1) step();
        check("on_drop", obs_m(1'b1), pack(4'b0, 1'b0, 1'b0, 1'b1, 2'd1));
        repeat (4 - L) step();
        kill = '0;
        repeat (4) step();
        check("fault_sticky", {31'd0, fault_o}, 32'd1);
        fault_clear();

        // Abort during the settle of segment 1.
        dly = 8'd3; tmo = 12'd10;
        repeat (3) step();
        base = cyc;
        t1 = 1 + L + 5;
        en = 1'b1;
        for (int s = 0; s < 64 && (cyc - base) < t1 + L + 2; s++) step();
        check("abort_pre", obs_m(1'b0), pack(4'b0011, 1'b0, 1'b1, 1'b0, 2'd0));
        en = 1'b0;
        step();
        check("abort_step1", obs_m(1'b0), pack(4'b0001, 1'b0, 1'b1, 1'b0, 2'd0));
        repeat (4) step();
        check("abort_step0", obs_m(1'b0), pack(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0));
        repeat (4) step();
        check("abort_off", obs_m(1'b0), pack(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0));

        // Zero timeout with power-good already asserted: no fault.
        loop_en = 1'b0; pgood = 4'hF; dly = 8'd1; tmo = 12'd0;
        repeat (3) step();
        base = cyc;
        en = 1'b1;
        repeat (12) step();
        check("tmo0_busy", obs_m(1'b0), pack(4'b1111, 1'b0, 1'b1, 1'b0, 2'd0));
        step();
        check("tmo0_on", obs_m(1'b0), pack(4'b1111, 1'b1, 1'b0, 1'b0, 2'd0));
        run_down(1);
        pgood = '0; loop_en = 1'b1;
        step();

        // Asynchronous reset in the middle of an up-sequence.
        dly = 8'd3; tmo = 12'd10; en = 1'b1;
        repeat (8) step();
        rst_n = 1'b0;
        #1 check("async_rst", obs_m(1'b1), 32'd0);
        en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();
        check("post_rst_off", obs_m(1'b1), 32'd0);

        // Random power-good delays and timing parameters.
        for (int it = 0; it < 20; it++) begin
            for (int k = 0; k < NUM_CH; k++)
                pdly[k] = ($urandom_range(0, 9) == 0) ? 200 : int'($urandom_range(0, 8));
            run_up(int'($urandom_range(0, 4)), int'($urandom_range(0, 12)), f);
            if (f) fault_clear();
            else   run_down(int'(dly));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
